// File: rtl/dump_pkg.sv
// -----------------------------------------------------------------------------
// dump_pkg
//   Shared definitions for the MIPS architectural-state dump engine:
//   record-kind codes, FSM state encoding, item-pointer layout and a helper
//   that maps an item number to its record kind.
//
//   Item layout walked by the dump, in order:
//     0            PC
//     1            current instruction word
//     2..33        register file r0..r31
//     34..         data-memory window (DM_WORDS words)
// -----------------------------------------------------------------------------
package dump_pkg;

  // Record kinds carried on out_kind
  localparam logic [1:0] KIND_PC   = 2'd0;
  localparam logic [1:0] KIND_INST = 2'd1;
  localparam logic [1:0] KIND_REG  = 2'd2;
  localparam logic [1:0] KIND_MEM  = 2'd3;

  // Item pointer: 34 + up to 256 memory words needs 9 bits
  localparam int ITEM_W = 9;

  localparam logic [ITEM_W-1:0] ITEM_PC   = 9'd0;
  localparam logic [ITEM_W-1:0] ITEM_INST = 9'd1;
  localparam logic [ITEM_W-1:0] ITEM_REG0 = 9'd2;
  localparam logic [ITEM_W-1:0] ITEM_MEM0 = 9'd34;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HALT = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [1:0] item_kind(input logic [ITEM_W-1:0] item);
    if (item == ITEM_PC)        return KIND_PC;
    else if (item == ITEM_INST) return KIND_INST;
    else if (item < ITEM_MEM0)  return KIND_REG;
    else                        return KIND_MEM;
  endfunction

endpackage

// File: rtl/dump_trigger.sv
// -----------------------------------------------------------------------------
// dump_trigger
//   Free-running 16-bit saturating cycle counter plus a one-shot "fired" flag.
//   Emits a single-cycle trig pulse the first time the counter equals
//   CYCLE_TRIGGER while the dump FSM is idle. CYCLE_TRIGGER = 0 disables it.
//   The counter only advances while the core runs, so it tracks core cycles.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset (clears counter and fired flag)
//   halt   in   core frozen; counter holds
//   idle   in   dump FSM is in IDLE
//   trig   out  one-cycle automatic dump request (combinational)
// -----------------------------------------------------------------------------
module dump_trigger #(
  parameter int CYCLE_TRIGGER = 45
) (
  input  logic clk,
  input  logic rst,
  input  logic halt,
  input  logic idle,
  output logic trig
);

  localparam logic [15:0] TRIG_AT  = 16'(CYCLE_TRIGGER);
  localparam bit          TRIG_EN  = (CYCLE_TRIGGER != 0);

  logic [15:0] cnt;
  logic        fired;

  if (CYCLE_TRIGGER < 0 || CYCLE_TRIGGER > 65535) begin : g_bad_trigger
    $error("dump_trigger: CYCLE_TRIGGER must fit in 16 bits");
  end

  assign trig = TRIG_EN && !fired && idle && (cnt == TRIG_AT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      fired <= 1'b0;
    end else begin
      if (!halt && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
      if (trig)
        fired <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_state_dump.sv
// -----------------------------------------------------------------------------
// mips_state_dump
//   Freezes the single-cycle MIPS core on a start pulse (or after a programmed
//   number of cycles) and streams its architectural state as tagged records:
//   PC, current instruction, r0..r31, then a window of data memory.
//
//   Per record the FSM spends one ADDR cycle presenting the debug read address
//   (register file / data memory read combinationally) and one or more DATA
//   cycles holding the registered record until the sink accepts it.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle manual dump request (ignored while busy)
//   resume            in DONE: release the core and return to IDLE
//   pc_in, inst_in    core PC and current instruction word
//   rf_raddr/rf_rdata register-file debug read port
//   dm_raddr/dm_rdata data-memory debug read port (word address)
//   cpu_halt          freezes PC, RF and DM writes
//   busy              dump in progress (HALT .. streaming)
//   done              dump complete, core still halted
//   out_*             record stream, valid/ready handshake
// -----------------------------------------------------------------------------
module mips_state_dump
  import dump_pkg::*;
#(
  parameter int CYCLE_TRIGGER = 45,
  parameter int DM_WORDS      = 9,
  parameter int DM_BASE_WORD  = 0,
  parameter int DM_AW         = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resume,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      inst_in,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic [DM_AW-1:0] dm_raddr,
  input  logic [31:0]      dm_rdata,
  output logic             cpu_halt,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [7:0]       out_index,
  output logic [31:0]      out_data,
  output logic             out_last
);

  localparam logic [ITEM_W-1:0] ITEM_LAST = ITEM_W'(34 + DM_WORDS - 1);

  if (DM_WORDS < 1 || DM_WORDS > 256) begin : g_bad_words
    $error("mips_state_dump: DM_WORDS must be in 1..256");
  end
  if (DM_BASE_WORD < 0 || (DM_BASE_WORD + DM_WORDS - 1) >= (1 << DM_AW)) begin : g_bad_window
    $error("mips_state_dump: dump window exceeds DM_AW address space");
  end

  state_t      state;
  logic [ITEM_W-1:0] item;
  logic [31:0] pc_hold;
  logic [31:0] inst_hold;
  logic        trig;

  dump_trigger #(
    .CYCLE_TRIGGER(CYCLE_TRIGGER)
  ) u_trigger (
    .clk  (clk),
    .rst  (rst),
    .halt (cpu_halt),
    .idle (state == ST_IDLE),
    .trig (trig)
  );

  // Debug read addresses for an item; zero for items that read neither port
  function automatic logic [4:0] rf_addr_of(input logic [ITEM_W-1:0] it);
    if (it >= ITEM_REG0 && it < ITEM_MEM0) return 5'(it - ITEM_REG0);
    return '0;
  endfunction

  function automatic logic [DM_AW-1:0] dm_addr_of(input logic [ITEM_W-1:0] it);
    if (it >= ITEM_MEM0) return DM_AW'(DM_BASE_WORD) + DM_AW'(it - ITEM_MEM0);
    return '0;
  endfunction

  function automatic logic [7:0] index_of(input logic [ITEM_W-1:0] it);
    if (it >= ITEM_MEM0)      return 8'(it - ITEM_MEM0);
    else if (it >= ITEM_REG0) return 8'(it - ITEM_REG0);
    return '0;
  endfunction

  // Record payload for the current item; r0 is architecturally zero even if
  // the debug port reads something else
  logic [31:0] item_data;
  always_comb begin
    item_data = '0;
    case (item_kind(item))
      KIND_PC:   item_data = pc_hold;
      KIND_INST: item_data = inst_hold;
      KIND_REG:  item_data = (item == ITEM_REG0) ? 32'd0 : rf_rdata;
      default:   item_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      item      <= '0;
      pc_hold   <= '0;
      inst_hold <= '0;
      rf_raddr  <= '0;
      dm_raddr  <= '0;
      cpu_halt  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_kind  <= '0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start and trig together still yield one dump
          if (start || trig) begin
            state    <= ST_HALT;
            cpu_halt <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_HALT: begin
          // Core is frozen this cycle, so PC/inst are stable to capture
          pc_hold   <= pc_in;
          inst_hold <= inst_in;
          item      <= ITEM_PC;
          rf_raddr  <= '0;
          dm_raddr  <= '0;
          state     <= ST_ADDR;
        end

        ST_ADDR: begin
          out_valid <= 1'b1;
          out_kind  <= item_kind(item);
          out_index <= index_of(item);
          out_data  <= item_data;
          out_last  <= (item == ITEM_LAST);
          rf_raddr  <= '0;
          dm_raddr  <= '0;
          state     <= ST_DATA;
        end

        ST_DATA: begin
          // out_valid is always high here, so out_ready alone is the handshake
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (item == ITEM_LAST) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              item     <= item + 9'd1;
              rf_raddr <= rf_addr_of(item + 9'd1);
              dm_raddr <= dm_addr_of(item + 9'd1);
              state    <= ST_ADDR;
            end
          end
        end

        ST_DONE: begin
          if (start) begin
            state <= ST_HALT;
            done  <= 1'b0;
            busy  <= 1'b1;
          end else if (resume) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            cpu_halt <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_state_dump.sv
// -----------------------------------------------------------------------------
// tb_mips_state_dump
//   Bench for mips_state_dump with a tiny core model: PC advances by 4 each
//   unhalted cycle, the instruction word and register/memory contents are
//   fixed functions of their addresses. Expected records go to a queue when a
//   dump is requested and are popped on every accepted record.
// -----------------------------------------------------------------------------
module tb_mips_state_dump;
  import dump_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        resume = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] core_pc;
  logic [31:0] inst_in;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [9:0]  dm_raddr;
  logic [31:0] dm_rdata;
  logic        cpu_halt, busy, done, out_valid, out_last;
  logic [1:0]  out_kind;
  logic [7:0]  out_index;
  logic [31:0] out_data;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  index;
    logic [31:0] data;
    logic        last;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Core model: PC frozen while halted, cleared by reset
  always_ff @(posedge clk) begin
    if (rst)            core_pc <= 32'd0;
    else if (!cpu_halt) core_pc <= core_pc + 32'd4;
  end

  // r0 deliberately reads nonzero to prove the dump forces it to zero
  assign inst_in  = {16'h2108, core_pc[15:0]};
  assign rf_rdata = 32'h1000_0000 | {19'd0, rf_raddr, 8'h5A};
  assign dm_rdata = {20'hD0000, dm_raddr, 2'b00};

  mips_state_dump #(
    .CYCLE_TRIGGER(45),
    .DM_WORDS     (9),
    .DM_BASE_WORD (0),
    .DM_AW        (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .resume    (resume),
    .pc_in     (core_pc),
    .inst_in   (inst_in),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dm_raddr  (dm_raddr),
    .dm_rdata  (dm_rdata),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_index (out_index),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [31:0] pc);
    rec_t r;
    r = '{KIND_PC, 8'd0, pc, 1'b0};
    exp_q.push_back(r);
    r = '{KIND_INST, 8'd0, {16'h2108, pc[15:0]}, 1'b0};
    exp_q.push_back(r);
    for (int i = 0; i < 32; i++) begin
      r.kind  = KIND_REG;
      r.index = 8'(i);
      r.data  = (i == 0) ? 32'd0 : (32'h1000_0000 | {19'd0, 5'(i), 8'h5A});
      r.last  = 1'b0;
      exp_q.push_back(r);
    end
    for (int w = 0; w < 9; w++) begin
      r.kind  = KIND_MEM;
      r.index = 8'(w);
      r.data  = {20'hD0000, 10'(w), 2'b00};
      r.last  = (w == 8);
      exp_q.push_back(r);
    end
  endtask

  // Accept records until the scoreboard empties. rnd toggles out_ready;
  // stray drives a start pulse on that cycle of the stream.
  task automatic drain(input bit rnd, input int stray, input string tag);
    int   cyc = 0;
    int   last_hs = -1;
    bit   stalled = 1'b0;
    rec_t held, cur, e;
    held = '0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (cyc == stray);
      cur = {out_kind, out_index, out_data, out_last};
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== held) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b %h want v=1 %h", tag, out_valid, cur, held);
        end
      end
      if (out_valid) begin
        if (out_ready) begin
          e = exp_q.pop_front();
          checks++;
          if (cur !== e) begin
            errors++;
            $display("FAIL %s record: got kind=%0d idx=%0d data=%h last=%b want kind=%0d idx=%0d data=%h last=%b",
                     tag, cur.kind, cur.index, cur.data, cur.last, e.kind, e.index, e.data, e.last);
          end
          if (!rnd && last_hs >= 0) begin
            checks++;
            if (cyc - last_hs != 2) begin
              errors++;
              $display("FAIL %s spacing: got %0d cycles want 2", tag, cyc - last_hs);
            end
          end
          last_hs = cyc;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = cur;
        end
      end
      tick();
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d records missing want 0", tag, exp_q.size());
      exp_q.delete();
    end
    // Stream must end in DONE with the core still frozen
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_halt !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: got done=%b busy=%b halt=%b valid=%b want 1 0 1 0",
               tag, done, busy, cpu_halt, out_valid);
    end
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string tag);
    int n = 0;
    while (core_pc != pc && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (core_pc !== pc) begin
      errors++;
      $display("FAIL %s wait_pc: got %h want %h", tag, core_pc, pc);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    resume = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({cpu_halt, busy, done, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {cpu_halt, busy, done, out_valid, out_last});
    end
    checks++;
    if ({out_kind, out_index, out_data, rf_raddr, dm_raddr} !== '0) begin
      errors++;
      $display("FAIL reset_data: got kind=%0d idx=%0d data=%h rf=%0d dm=%0d want all 0",
               out_kind, out_index, out_data, rf_raddr, dm_raddr);
    end
  endtask

  task automatic test_manual_start();
    logic [31:0] p;
    repeat (10) tick();
    start = 1'b1;
    push_dump(core_pc + 32'd4);
    tick();
    start = 1'b0;
    checks++;
    if (cpu_halt !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL manual halt_rise: got halt=%b busy=%b valid=%b want 1 1 0", cpu_halt, busy, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL manual early_valid: got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL manual first_valid: got %b want 1", out_valid);
    end
    drain(1'b0, 10, "manual");
    p = core_pc;
    repeat (4) tick();
    checks++;
    if (core_pc !== p || out_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL manual frozen: got pc=%h valid=%b done=%b want pc=%h 0 1", core_pc, out_valid, done, p);
    end
  endtask

  task automatic test_resume(input string tag);
    logic [31:0] p;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (cpu_halt !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s resume: got halt=%b done=%b busy=%b want 0 0 0", tag, cpu_halt, done, busy);
    end
    p = core_pc;
    tick();
    tick();
    checks++;
    if (core_pc !== p + 32'd8) begin
      errors++;
      $display("FAIL %s core_runs: got pc=%h want %h", tag, core_pc, p + 32'd8);
    end
  endtask

  task automatic test_auto_random();
    wait_pc(32'd180, "auto");
    push_dump(32'd184);
    tick();
    checks++;
    if (cpu_halt !== 1'b1 || core_pc !== 32'd184) begin
      errors++;
      $display("FAIL auto halt_at_45: got halt=%b pc=%h want 1 000000b8", cpu_halt, core_pc);
    end
    drain(1'b1, -1, "auto_rnd");
  endtask

  task automatic test_restart();
    bit seen = 1'b0;
    test_resume("restart");
    start = 1'b1;
    push_dump(core_pc + 32'd4);
    tick();
    start = 1'b0;
    drain(1'b0, -1, "restart");
    test_resume("restart2");
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cpu_halt) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL restart refire: got halt seen=1 want 0");
    end
  endtask

  task automatic test_same_cycle();
    bit extra = 1'b0;
    apply_reset();
    wait_pc(32'd180, "same");
    start = 1'b1;
    push_dump(32'd184);
    tick();
    start = 1'b0;
    drain(1'b0, 25, "same_cycle");
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) extra = 1'b1;
    end
    checks++;
    if (extra || done !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle second_dump: got extra=%b done=%b want 0 1", extra, done);
    end
  endtask

  task automatic test_rst_mid();
    int n = 0;
    bit found = 1'b0;
    apply_reset();
    wait_pc(32'd180, "rst_mid");
    while (n < 300) begin
      if (out_valid && out_kind == KIND_REG && out_index == 8'd10) begin
        found = 1'b1;
        break;
      end
      out_ready = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid reach_r10: got found=0 want 1");
    end
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || cpu_halt !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid abort: got valid=%b halt=%b busy=%b done=%b want 0 0 0 0",
               out_valid, cpu_halt, busy, done);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (core_pc != 32'd180 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 45) begin
      errors++;
      $display("FAIL rst_mid counter_restart: got %0d cycles want 45", n);
    end
    push_dump(32'd184);
    tick();
    drain(1'b0, -1, "after_rst");
    test_resume("after_rst");
  endtask

  initial begin
    test_reset();
    test_manual_start();
    test_resume("manual");
    test_auto_random();
    test_restart();
    test_same_cycle();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_state_dump.md
Name: mips_state_dump

Overview:
- Hardware reader for the single-cycle MIPS core's architectural state.
- On a start pulse or a programmed cycle count, it freezes the core and walks the register file and a window of data memory.
- It streams every value out as a tagged record on a valid/ready interface.
- It sits beside the `mips` top, on the core's debug read ports. It is the in-silicon counterpart of the bench state dump, so FPGA runs can be checked against the same expected values.

Parameters:
- CYCLE_TRIGGER, 45: free-running cycles after reset before an automatic dump; 0 disables the auto trigger.
- DM_WORDS, 9: number of data-memory words dumped (byte addresses 0x00..0x20 by default).
- DM_BASE_WORD, 0: first data-memory word index dumped.
- DM_AW, 10: data-memory word-address width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request for a manual dump.
- resume  in  1  in DONE: release the core and return to IDLE.
- pc_in  in  32  core PC.
- inst_in  in  32  core current instruction word.
- rf_raddr  out  5  register-file debug read address.
- rf_rdata  in  32  combinational register-file read data.
- dm_raddr  out  DM_AW  data-memory debug word address.
- dm_rdata  in  32  combinational data-memory read data.
- cpu_halt  out  1  freezes PC, register-file writes and data-memory writes.
- busy  out  1  dump in progress (HALT through STREAM).
- done  out  1  dump complete, core still halted.
- out_valid  out  1  record valid.
- out_ready  in  1  sink accepts the record.
- out_kind  out  2  record type: 0 = PC, 1 = INST, 2 = REG, 3 = MEM.
- out_index  out  8  register number or dumped-word offset (0 for PC and INST).
- out_data  out  32  record value.
- out_last  out  1  final record of the dump.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, the cycle counter is 0 and the auto-trigger fired flag is cleared. An rst mid-dump aborts immediately; the next cycle shows cpu_halt=0 and out_valid=0.
- Cycle counter:
  - 16-bit; increments on each clock with rst=0 and cpu_halt=0, and saturates.
  - Auto trigger fires when cnt == CYCLE_TRIGGER, fired=0 and the FSM is in IDLE, then sets fired.
  - An auto trigger and start in the same cycle produce a single dump.
- States: IDLE -> HALT -> ADDR -> DATA -> (ADDR | DONE).
- IDLE: cpu_halt=0. A start or the auto trigger moves to HALT, and cpu_halt is 1 from the next cycle.
- HALT:
  - Lasts exactly one cycle and samples pc_in and inst_in into holding registers.
  - Sets the item pointer to 0.
  - Items run in order: 0 = PC, 1 = INST, 2..33 = REG r0..r31, 34..33+DM_WORDS = MEM.
- ADDR:
  - Drives rf_raddr = item-2 for REG items and dm_raddr = DM_BASE_WORD + (item-34) for MEM items; addresses are otherwise held at 0.
  - Moves to DATA next cycle.
- DATA:
  - On entry, registers out_data from the holding register or from the read data, and asserts out_valid with out_kind and out_index.
  - A REG record for r0 always carries data 0.
  - out_last=1 only on the final MEM item.
  - out_valid, kind, index, data and last stay stable until out_valid & out_ready.
  - On that handshake, out_valid drops next cycle and the item pointer increments: to ADDR, or to DONE after the last item.
- Throughput: 2 cycles per record when out_ready is held 1. Total is 34+DM_WORDS records (43 by default). The first out_valid appears 3 cycles after the start cycle.
- DONE: done=1 and cpu_halt=1. resume moves to IDLE and clears done and cpu_halt next cycle. start in DONE begins a fresh dump through HALT.
- start is ignored while busy. resume is ignored outside DONE.
- The dump-word offset width is 8 bits, so DM_WORDS ≤ 256. DM_BASE_WORD+DM_WORDS-1 must fit in DM_AW bits; this is elaboration-checked.

Decomposition:
- Shared package `dump_pkg`:
  - record-kind constants KIND_PC/KIND_INST/KIND_REG/KIND_MEM;
  - FSM state encodings;
  - item offsets ITEM_REG0 = 2 and ITEM_MEM0 = 34.
- One natural sub-module: `dump_trigger`, the saturating cycle counter plus the one-shot fired flag, producing a single-cycle trigger pulse.

Test Plan:
- rst pulse, then free run, out_ready=1 → at counter 45, cpu_halt rises. 43 records follow: PC, INST, REG r0..r31 (r0 data 0), MEM words 0..8, with out_last only on MEM index 8. done=1, and the PC no longer advances.
- Manual start at cycle 10 with CYCLE_TRIGGER=0 → first out_valid at cycle 13, kind=0, data = the PC sampled in HALT.
- out_ready toggled 1-0-0-1 randomly → each record holds stable while stalled, no record is duplicated or dropped, and the index sequence is contiguous.
- start and the auto trigger asserted in the same cycle → exactly one dump of 43 records. A second start while busy is ignored.
- rst asserted during REG r10 → next cycle out_valid=0, cpu_halt=0, busy=0. The counter restarts and the auto dump recurs 45 cycles later.
- In DONE, pulse resume → cpu_halt=0 next cycle and the core resumes. Then start → a new 43-record dump, and the auto trigger does not fire again.
